atax_stream: RTL
================

# atax_stream

Parametrised, streaming successor to the fixed-size ATAX kernel in the polybench set. It computes y = Aᵀ·(A·x) on signed fixed-point integers; a mode bit selects A·x only. A and x arrive on one valid/ready input stream, and results leave on a valid/ready output stream. A single time-shared MAC keeps area independent of N.

## Interface
- N, default 8: matrix dimension (A is N×N, x and y have N entries); must be ≥ 2.
- DW, default 16: element width of A and x, signed two's complement.
- ACC_W, default 48: accumulator/result width, signed; must be ≥ 2·DW.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  begin a job; honoured only in IDLE.
- mode  in  1  sampled with start: 1 = ATAX (y = Aᵀ·A·x), 0 = AX (y = A·x).
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  DW  x elements, then A row-major.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_data  out  ACC_W  y[k].
- m_last  out  1  high with y[N-1].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final output handshake.

## Operation
- States: IDLE, LOAD_X, ROW, SCALE, OUT.
- IDLE:
  - On start, latch mode, clear all y accumulators and counters, then go to LOAD_X.
- LOAD_X:
  - s_ready = 1.
  - Store N beats into x[0..N-1], then go to ROW with i = 0.
- ROW:
  - s_ready = 1.
  - Beat j is A[i][j]: store it in row[j] and update acc += sext(A[i][j]·x[j]).
  - On beat N-1, the final value is tmp = acc + product; acc is cleared.
  - ATAX mode: register tmp and go to SCALE.
  - AX mode: write y[i] = tmp. If i < N-1, increment i and stay in ROW; otherwise go to OUT.
- SCALE (ATAX only):
  - s_ready = 0.
  - Over N cycles, j = 0..N-1: y[j] += low ACC_W bits of (row[j]·tmp).
  - Then increment i and return to ROW; after i = N-1, go to OUT.
- OUT:
  - m_valid = 1 and m_data = y[k], with k starting at 0; m_last = (k == N-1).
  - k advances on each m_valid && m_ready.
  - After the handshake with k = N-1, pulse done, clear m_valid and return to IDLE.
- Arithmetic:
  - DW×DW products are sign-extended to ACC_W.
  - The DW×ACC_W product in SCALE is truncated to its low ACC_W bits.
  - All sums wrap modulo 2^ACC_W; there is no saturation and no overflow flag.
- s_valid low inserts stall cycles in LOAD_X and ROW; state and counters hold.
- In SCALE, OUT and IDLE, s_ready = 0 and s_data is ignored.
- start while busy is ignored; mode is not re-sampled.

## Timing
- Reset (reset low at a clock edge) forces the following, regardless of state, including mid-job:
  - state = IDLE;
  - s_ready = 0, m_valid = 0, m_last = 0, m_data = 0;
  - busy = 0, done = 0;
  - accumulators and counters = 0.
- x and A contents need no reset.
- busy rises the cycle after start is sampled.
- Latency with s_valid held high and m_ready held high:
  - ATAX: N cycles (LOAD_X) + N·2N cycles (ROW + SCALE) to first m_valid, then N output cycles. For N = 4: 4 + 32 = 36 cycles.
  - AX: N + N² cycles to first m_valid.
- m_data and m_last are registered and stable while m_valid && !m_ready.
- done is asserted in the cycle after the last handshake, concurrent with busy falling; a new start is accepted in that same cycle.
- The MAC is one multiply per cycle and needs no pipeline bubbles. An internal multiply register is allowed if the latency figures above still hold exactly.

## Test plan
- N=4, DW=16, ATAX, A = identity, x = [1,2,3,4] -> y = [1,2,3,4]; m_last on the 4th beat; done pulses once.
- N=4, ATAX, A all 1, x all 1 -> tmp_i = 4, y = [16,16,16,16]; first m_valid exactly 36 cycles after start.
- N=4, AX, A[i][j] = i+1, x all 1 -> y = [4,8,12,16]; SCALE is never entered (s_ready never drops between rows).
- N=4, ATAX, A = 2·I, x all -1 -> y = [-4,-4,-4,-4] (sign-correct in ACC_W).
- Random A and x, with s_valid gapped 50% and m_ready toggling, compared against a golden model -> exact match, and no data change while m_valid && !m_ready.
- reset pulsed mid-ROW, then a fresh job with A = I, x = [5,6,7,8] -> all outputs 0 during reset, then y = [5,6,7,8] with no residue from the aborted job.

Source files
------------

// File: rtl/atax_stream.sv
// atax_stream: streaming y = A^T*(A*x) (or A*x) through one time-shared signed MAC
module atax_stream #(
  parameter int N     = 8,
  parameter int DW    = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(N);
  typedef enum logic [2:0] {IDLE, LOAD_X, ROW, SCALE, OUT} state_t;
  state_t state_q, state_d;
  logic mode_q, mode_d, done_q, done_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, tmp_q, tmp_d, tmp;
  logic signed [ACC_W-1:0] y_q [N];
  logic signed [ACC_W-1:0] y_d [N];
  logic signed [DW-1:0] x_q [N];
  logic signed [DW-1:0] x_d [N];
  logic signed [DW-1:0] row_q [N];
  logic signed [DW-1:0] row_d [N];
  logic signed [ACC_W-1:0] mac_a, mac_b, prod;
  logic s_fire, m_fire, last_j, last_i;
  assign s_ready = state_q == LOAD_X || state_q == ROW;
  assign m_valid = state_q == OUT;
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;
  assign last_j  = j_q == CW'(N - 1);
  assign last_i  = i_q == CW'(N - 1);
  assign m_data  = m_valid ? y_q[j_q] : '0;
  assign m_last  = m_valid && last_j;
  assign busy    = state_q != IDLE;
  assign done    = done_q;
  // one multiplier: A*x while streaming rows, row*tmp while scaling into y
  assign mac_a = ACC_W'((state_q == SCALE) ? row_q[j_q] : $signed(s_data));
  assign mac_b = (state_q == SCALE) ? tmp_q : ACC_W'(x_q[j_q]);
  assign prod  = mac_a * mac_b;
  assign tmp   = acc_q + prod;
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    tmp_d   = tmp_q;
    y_d     = y_q;
    x_d     = x_q;
    row_d   = row_q;
    case (state_q)
      IDLE: if (start) begin
        mode_d  = mode;
        i_d     = '0;
        j_d     = '0;
        acc_d   = '0;
        y_d     = '{default: '0};
        state_d = LOAD_X;
      end
      LOAD_X: if (s_fire) begin
        x_d[j_q] = s_data;
        j_d      = last_j ? '0 : j_q + 1'b1;
        state_d  = last_j ? ROW : LOAD_X;
      end
      ROW: if (s_fire) begin
        row_d[j_q] = s_data;
        j_d        = last_j ? '0 : j_q + 1'b1;
        acc_d      = last_j ? '0 : tmp;
        if (last_j && mode_q) begin
          tmp_d   = tmp;
          state_d = SCALE;
        end else if (last_j) begin
          y_d[i_q] = tmp;
          i_d      = last_i ? '0 : i_q + 1'b1;
          state_d  = last_i ? OUT : ROW;
        end
      end
      SCALE: begin
        y_d[j_q] = y_q[j_q] + prod;
        j_d      = last_j ? '0 : j_q + 1'b1;
        if (last_j) begin
          i_d     = last_i ? '0 : i_q + 1'b1;
          state_d = last_i ? OUT : ROW;
        end
      end
      OUT: if (m_fire) begin
        j_d     = last_j ? '0 : j_q + 1'b1;
        done_d  = last_j;
        state_d = last_j ? IDLE : OUT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      tmp_q   <= '0;
      y_q     <= '{default: '0};
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      tmp_q   <= tmp_d;
      y_q     <= y_d;
    end
  end
  always_ff @(posedge clk) begin
    x_q   <= x_d;
    row_q <= row_d;
  end
endmodule
